// File: rtl/i2c_pkt_pkg.sv
// Shared types and constants for the I2C packet scheduler.
package i2c_pkt_pkg;

    localparam int unsigned PKT_LEN        = 7;
    localparam logic [7:0]  WIN_BYTE       = 8'h01;
    localparam logic [6:0]  DEF_SLAVE_ADDR = 7'h17;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StStart,
        StWait,
        StData,
        StStop,
        StWaitStop,
        StDone
    } state_e;

endpackage

// File: rtl/i2c_req_arb.sv
// Sticky request flags with fixed evt-over-ball priority grant.
module i2c_req_arb (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ball_req_i,
    input  logic evt_req_i,
    input  logic arb_en_i,
    output logic grant_ball_o,
    output logic grant_evt_o
);

    logic pend_ball_q, pend_ball_d;
    logic pend_evt_q, pend_evt_d;

    always_comb begin
        grant_evt_o  = arb_en_i & pend_evt_q;
        grant_ball_o = arb_en_i & pend_ball_q & ~pend_evt_q;
        // A request landing in the grant cycle re-arms the flag for a follow-up packet.
        pend_evt_d   = (pend_evt_q & ~grant_evt_o) | evt_req_i;
        pend_ball_d  = (pend_ball_q & ~grant_ball_o) | ball_req_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_ball_q <= 1'b0;
            pend_evt_q  <= 1'b0;
        end else begin
            pend_ball_q <= pend_ball_d;
            pend_evt_q  <= pend_evt_d;
        end
    end

endmodule

// File: rtl/i2c_pkt_scheduler.sv
// Sequences a 7-byte ball/win-event packet to an I2C byte master.
// Optional per-byte watchdog enabled by defining I2C_TIMEOUT_EN.
module i2c_pkt_scheduler
    import i2c_pkt_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = DEF_SLAVE_ADDR,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ball_req,
    input  logic       evt_req,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_vy,
    input  logic [1:0] gravity_counter,
    input  logic       is_collusion,
    input  logic       ready,
    input  logic       tx_done,
    output logic       i2c_en,
    output logic       start,
    output logic       stop,
    output logic [7:0] tx_data,
    output logic       ball_ack,
    output logic       evt_ack,
    output logic       is_transfer,
    output logic       is_i2c_master_done,
    output logic       err
);

    state_e                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [PKT_LEN-1:0][7:0] pkt_q, pkt_d;
    logic                    en_q, en_d, start_q, start_d, stop_q, stop_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    ball_ack_q, ball_ack_d, evt_ack_q, evt_ack_d;
    logic                    xfer_q, xfer_d, done_q, done_d;
    logic                    grant_ball, grant_evt;

`ifdef I2C_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            tmo_hit;
    assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYC - 1));
    assign err     = err_q;
`else
    logic unused_tmo_cyc;
    assign unused_tmo_cyc = ^TIMEOUT_CYC;
    assign err            = 1'b0;
`endif

    i2c_req_arb u_arb (
        .clk_i       (clk),
        .rst_i       (reset),
        .ball_req_i  (ball_req),
        .evt_req_i   (evt_req),
        .arb_en_i    (state_q == StIdle),
        .grant_ball_o(grant_ball),
        .grant_evt_o (grant_evt)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pkt_d      = pkt_q;
        en_d       = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        tx_data_d  = tx_data_q;
        ball_ack_d = 1'b0;
        evt_ack_d  = 1'b0;
        xfer_d     = xfer_q;
        done_d     = 1'b0;
`ifdef I2C_TIMEOUT_EN
        err_d      = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_evt || grant_ball) begin
                    pkt_d[0]   = {SLAVE_ADDR, 1'b0};
                    pkt_d[1]   = ball_y[7:0];
                    pkt_d[2]   = {6'b0, ball_y[9:8]};
                    pkt_d[3]   = ball_vy;
                    pkt_d[4]   = {6'b0, gravity_counter};
                    pkt_d[5]   = {7'b0, is_collusion};
                    pkt_d[6]   = grant_evt ? WIN_BYTE : 8'h00;
                    idx_d      = '0;
                    ball_ack_d = grant_ball;
                    evt_ack_d  = grant_evt;
                    xfer_d     = 1'b1;
                    state_d    = StLatch;
                end
            end
            StLatch: state_d = StStart;
            StStart: begin
                if (ready) begin
                    en_d      = 1'b1;
                    start_d   = 1'b1;
                    tx_data_d = pkt_q[0];
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (tx_done) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = (idx_q == 3'(PKT_LEN - 1)) ? StStop : StData;
                end
`ifdef I2C_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StStop;
                end
`endif
            end
            StData: begin
                if (ready) begin
                    en_d      = 1'b1;
                    tx_data_d = pkt_q[idx_q];
                    state_d   = StWait;
                end
            end
            StStop: begin
                if (ready) begin
                    en_d    = 1'b1;
                    stop_d  = 1'b1;
                    state_d = StWaitStop;
                end
            end
            StWaitStop: begin
                if (ready) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end
`ifdef I2C_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                xfer_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
`ifdef I2C_TIMEOUT_EN
        // Counts only while parked in a wait state; any state entry restarts it.
        tmo_d = ((state_d == state_q) && (state_q == StWait || state_q == StWaitStop)) ?
                tmo_q + 1'b1 : '0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            pkt_q      <= '0;
            en_q       <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            tx_data_q  <= '0;
            ball_ack_q <= 1'b0;
            evt_ack_q  <= 1'b0;
            xfer_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef I2C_TIMEOUT_EN
            tmo_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pkt_q      <= pkt_d;
            en_q       <= en_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            tx_data_q  <= tx_data_d;
            ball_ack_q <= ball_ack_d;
            evt_ack_q  <= evt_ack_d;
            xfer_q     <= xfer_d;
            done_q     <= done_d;
`ifdef I2C_TIMEOUT_EN
            tmo_q      <= tmo_d;
            err_q      <= err_d;
`endif
        end
    end

    assign i2c_en             = en_q;
    assign start              = start_q;
    assign stop               = stop_q;
    assign tx_data            = tx_data_q;
    assign ball_ack           = ball_ack_q;
    assign evt_ack            = evt_ack_q;
    assign is_transfer        = xfer_q;
    assign is_i2c_master_done = done_q;

endmodule

// File: doc/i2c_pkt_scheduler.md
I2C_PKT_SCHEDULER -- requirements
Module: i2c_pkt_scheduler

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h17: 7-bit target address sent in byte 0 as {SLAVE_ADDR,1'b0}.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 20000: per-byte watchdog limit in clk cycles, used only under I2C_TIMEOUT_EN.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports ball_req (in, 1, ball packet request pulse) and evt_req (in, 1, win-event packet request pulse).
REQ-006 SHALL have ports ball_y (in, 10), ball_vy (in, 8), gravity_counter (in, 2) and is_collusion (in, 1): live payload sources.
REQ-007 SHALL have ports ready (in, 1, master idle or between bytes) and tx_done (in, 1, one-cycle pulse per byte shifted).
REQ-008 SHALL have ports i2c_en, start, stop (out, 1 each) and tx_data (out, 8): command strobes and data to the master.
REQ-009 SHALL have ports ball_ack and evt_ack (out, 1 each): one-cycle grant pulses.
REQ-010 SHALL have ports is_transfer (out, 1, high from grant to DONE), is_i2c_master_done (out, 1, one-cycle end-of-packet pulse) and err (out, 1, one-cycle timeout pulse).

Function
REQ-011 Request pulses SHALL set sticky pend_ball / pend_evt flags; repeated pulses while pending SHALL coalesce; a grant SHALL clear the granted flag in the same cycle.
REQ-012 Arbitration in IDLE SHALL be fixed priority evt over ball; if both are pending, evt is granted and ball stays pending.
REQ-013 On grant (IDLE->LATCH), the 7-byte packet SHALL be snapshotted from live inputs: b0={SLAVE_ADDR,0}, b1=ball_y[7:0], b2={6'b0,ball_y[9:8]}, b3=ball_vy, b4={6'b0,gravity_counter}, b5={7'b0,is_collusion}, b6=8'h01 for evt, else 8'h00.
REQ-014 States SHALL be IDLE, LATCH, START, WAIT, DATA, STOP, WAIT_STOP, DONE.
REQ-015 LATCH SHALL last one cycle, pulse the matching ack, then go to START.
REQ-016 START with ready=1 SHALL drive i2c_en=1, start=1, tx_data=b0 for exactly one cycle, then go to WAIT; with ready=0 it SHALL hold with strobes low.
REQ-017 WAIT on tx_done SHALL increment 3-bit idx; idx==6 before increment -> STOP, else -> DATA.
REQ-018 DATA with ready=1 SHALL drive i2c_en=1, start=0, tx_data=b[idx] for one cycle, then go to WAIT.
REQ-019 STOP with ready=1 SHALL drive i2c_en=1, stop=1 for one cycle, then go to WAIT_STOP; WAIT_STOP SHALL wait for ready=1, then go to DONE.
REQ-020 DONE SHALL pulse is_i2c_master_done for one cycle, then go to IDLE; the next grant is earliest on the following cycle.
REQ-021 tx_data SHALL hold its last value when i2c_en=0; start and stop SHALL never be high together.
REQ-022 Requests arriving mid-packet SHALL only set pending flags; the in-flight snapshot SHALL NOT change.
REQ-023 A tx_done outside WAIT SHALL be ignored.

Reset
REQ-024 Reset SHALL force IDLE, clear idx, pending flags and snapshot, and drive every output to 0, including mid-packet with no STOP issued.

Configuration
REQ-025 With I2C_TIMEOUT_EN defined, a counter SHALL run in WAIT and WAIT_STOP; reaching TIMEOUT_CYC SHALL pulse err, go to STOP (from WAIT) or DONE (from WAIT_STOP), and clear the counter on each state entry.
REQ-026 Without I2C_TIMEOUT_EN, there SHALL be no counter, err SHALL be tied to 0, and WAIT / WAIT_STOP SHALL wait indefinitely.

Structure
REQ-027 Package i2c_pkt_pkg SHALL hold the state enum, PKT_LEN=7, WIN_BYTE=8'h01 and the default SLAVE_ADDR.
REQ-028 Sub-module i2c_req_arb SHALL contain the pending flags and priority grant; the sequencer FSM stays in i2c_pkt_scheduler.

Verification
REQ-029 ball_req with ball_y=10'h2A5, ball_vy=8'h7E, gravity_counter=2, is_collusion=1 -> tx_data sequence 2E,A5,02,7E,02,01,00, one start, one stop, one done pulse.
REQ-030 ball_req and evt_req in the same cycle -> evt_ack first with b6=01, then ball packet with b6=00, with no gap beyond the DONE cycle.
REQ-031 Hold ready=0 for 50 cycles in DATA -> no strobe, tx_data stable; release -> one i2c_en pulse.
REQ-032 Reset asserted after the third tx_done -> all outputs 0 within the same cycle, IDLE, pending flags cleared.
REQ-033 With I2C_TIMEOUT_EN and TIMEOUT_CYC=100, withhold tx_done -> err at cycle 100 of WAIT, then stop strobe and done pulse.
REQ-034 Three ball_req pulses during one packet -> exactly one follow-up ball packet.
